// File: rtl/rv_decode_stage.sv
// rv_decode_stage: registered RV32I/RV64I decode stage between fetch and execute.
// Decodes the base opcode classes, builds sign-extended immediates, flags illegal
// encodings and counts accepted illegal instructions (saturating).
// Optional feature macro: RV_DECODE_MULDIV_EN adds the M-extension OP decodes.

package rv_pkg;
  typedef enum logic [4:0] {
    OP_ADD,
    OP_SUB,
    OP_AND,
    OP_OR,
    OP_NOP,
    OP_XOR,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_SLT,
    OP_SLTU
`ifdef RV_DECODE_MULDIV_EN
    ,
    OP_MUL,
    OP_MULH,
    OP_MULHSU,
    OP_MULHU,
    OP_DIV,
    OP_DIVU,
    OP_REM,
    OP_REMU
`endif
  } alu_operations_e;
endpackage

module rv_decode_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ILL_CNT_W = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  logic [31:0]               instr_i,
  input  logic [XLEN-1:0]           pc_i,
  input  logic                      flush_i,
  output logic                      dec_valid_o,
  input  logic                      dec_ready_i,
  output logic [4:0]                rs_addr_a_o,
  output logic [4:0]                rs_addr_b_o,
  output logic [4:0]                rd_addr_o,
  output logic [XLEN-1:0]           imm_o,
  output logic [XLEN-1:0]           pc_o,
  output logic                      alu_src_o,
  output rv_pkg::alu_operations_e   alu_ctrl_o,
  output logic                      rd_we_o,
  output logic                      mem_re_o,
  output logic                      mem_we_o,
  output logic                      branch_o,
  output logic                      jump_o,
  output logic                      dec_illegal_o,
  output logic [ILL_CNT_W-1:0]      ill_cnt_o
);
  import rv_pkg::*;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  logic [XLEN-1:0] imm_i_fmt, imm_s_fmt, imm_b_fmt, imm_u_fmt, imm_j_fmt;

  assign imm_i_fmt = XLEN'($signed(instr_i[31:20]));
  assign imm_s_fmt = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
  assign imm_b_fmt = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
  assign imm_u_fmt = XLEN'($signed({instr_i[31:12], 12'b0}));
  assign imm_j_fmt = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));

  // Shared funct3 -> ALU op mapping for OP and OP-IMM; alt selects SRA over SRL.
  function automatic alu_operations_e base_alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  base_alu_op = OP_ADD;
      3'b001:  base_alu_op = OP_SLL;
      3'b010:  base_alu_op = OP_SLT;
      3'b011:  base_alu_op = OP_SLTU;
      3'b100:  base_alu_op = OP_XOR;
      3'b101:  base_alu_op = alt ? OP_SRA : OP_SRL;
      3'b110:  base_alu_op = OP_OR;
      default: base_alu_op = OP_AND;
    endcase
  endfunction

  logic [4:0]      rs_addr_a_d;
  logic [XLEN-1:0] imm_d;
  logic            alu_src_d;
  alu_operations_e alu_ctrl_d;
  logic            rd_we_d, mem_re_d, mem_we_d, branch_d, jump_d, illegal_d;

  // Combinational decode of the offered instruction into next-state bundle fields.
  always_comb begin
    rs_addr_a_d = instr_i[19:15];
    imm_d       = '0;
    alu_src_d   = 1'b0;
    alu_ctrl_d  = OP_ADD;
    rd_we_d     = 1'b0;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    branch_d    = 1'b0;
    jump_d      = 1'b0;
    illegal_d   = 1'b0;

    case (opcode)
      OPC_LUI: begin
        imm_d       = imm_u_fmt;
        alu_src_d   = 1'b1;
        rd_we_d     = 1'b1;
        rs_addr_a_d = 5'd0;
      end
      OPC_AUIPC: begin
        imm_d     = imm_u_fmt;
        alu_src_d = 1'b1;
        rd_we_d   = 1'b1;
      end
      OPC_JAL: begin
        imm_d     = imm_j_fmt;
        alu_src_d = 1'b1;
        rd_we_d   = 1'b1;
        jump_d    = 1'b1;
      end
      OPC_JALR: begin
        imm_d     = imm_i_fmt;
        alu_src_d = 1'b1;
        rd_we_d   = 1'b1;
        jump_d    = 1'b1;
        if (funct3 != 3'b000) illegal_d = 1'b1;
      end
      OPC_BRANCH: begin
        imm_d    = imm_b_fmt;
        branch_d = 1'b1;
        case (funct3)
          3'b000, 3'b001: alu_ctrl_d = OP_SUB;
          3'b100, 3'b101: alu_ctrl_d = OP_SLT;
          3'b110, 3'b111: alu_ctrl_d = OP_SLTU;
          default:        illegal_d  = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        imm_d     = imm_i_fmt;
        alu_src_d = 1'b1;
        rd_we_d   = 1'b1;
        mem_re_d  = 1'b1;
      end
      OPC_STORE: begin
        imm_d     = imm_s_fmt;
        alu_src_d = 1'b1;
        mem_we_d  = 1'b1;
      end
      OPC_OPIMM: begin
        imm_d      = imm_i_fmt;
        alu_src_d  = 1'b1;
        rd_we_d    = 1'b1;
        alu_ctrl_d = (funct3 == 3'b000) ? OP_ADD : base_alu_op(funct3, instr_i[30]);
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          if (instr_i[31:26] != 6'b000000 && instr_i[31:26] != 6'b010000) illegal_d = 1'b1;
          if (XLEN == 32 && instr_i[25]) illegal_d = 1'b1;
        end
      end
      OPC_OP: begin
        rd_we_d = 1'b1;
        case (funct7)
          7'b0000000: alu_ctrl_d = base_alu_op(funct3, 1'b0);
          7'b0100000: begin
            case (funct3)
              3'b000:  alu_ctrl_d = OP_SUB;
              3'b101:  alu_ctrl_d = OP_SRA;
              default: illegal_d  = 1'b1;
            endcase
          end
`ifdef RV_DECODE_MULDIV_EN
          7'b0000001: begin
            case (funct3)
              3'b000:  alu_ctrl_d = OP_MUL;
              3'b001:  alu_ctrl_d = OP_MULH;
              3'b010:  alu_ctrl_d = OP_MULHSU;
              3'b011:  alu_ctrl_d = OP_MULHU;
              3'b100:  alu_ctrl_d = OP_DIV;
              3'b101:  alu_ctrl_d = OP_DIVU;
              3'b110:  alu_ctrl_d = OP_REM;
              default: alu_ctrl_d = OP_REMU;
            endcase
          end
`endif
          default: illegal_d = 1'b1;
        endcase
      end
      default: illegal_d = 1'b1;
    endcase

    if (instr_i[1:0] != 2'b11) illegal_d = 1'b1;

    if (illegal_d) begin
      rd_we_d    = 1'b0;
      mem_re_d   = 1'b0;
      mem_we_d   = 1'b0;
      branch_d   = 1'b0;
      jump_d     = 1'b0;
      alu_ctrl_d = OP_NOP;
    end
  end

  logic                 dec_valid_q;
  logic [4:0]           rs_addr_a_q, rs_addr_b_q, rd_addr_q;
  logic [XLEN-1:0]      imm_q, pc_q;
  logic                 alu_src_q;
  alu_operations_e      alu_ctrl_q;
  logic                 rd_we_q, mem_re_q, mem_we_q, branch_q, jump_q, illegal_q;
  logic [ILL_CNT_W-1:0] ill_cnt_q;
  logic                 xfer;

  assign instr_ready_o = !dec_valid_q || dec_ready_i;
  assign xfer          = instr_valid_i && instr_ready_o;

  // Output register: flush beats a transfer, a transfer loads the bundle, a lone consume empties it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dec_valid_q <= 1'b0;
      rs_addr_a_q <= '0;
      rs_addr_b_q <= '0;
      rd_addr_q   <= '0;
      imm_q       <= '0;
      pc_q        <= '0;
      alu_src_q   <= 1'b0;
      alu_ctrl_q  <= OP_NOP;
      rd_we_q     <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      branch_q    <= 1'b0;
      jump_q      <= 1'b0;
      illegal_q   <= 1'b0;
      ill_cnt_q   <= '0;
    end else if (flush_i) begin
      dec_valid_q <= 1'b0;
    end else if (xfer) begin
      dec_valid_q <= 1'b1;
      rs_addr_a_q <= rs_addr_a_d;
      rs_addr_b_q <= instr_i[24:20];
      rd_addr_q   <= instr_i[11:7];
      imm_q       <= imm_d;
      pc_q        <= pc_i;
      alu_src_q   <= alu_src_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rd_we_q     <= rd_we_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      branch_q    <= branch_d;
      jump_q      <= jump_d;
      illegal_q   <= illegal_d;
      if (illegal_d && !(&ill_cnt_q)) ill_cnt_q <= ill_cnt_q + 1'b1;
    end else if (dec_ready_i) begin
      dec_valid_q <= 1'b0;
    end
  end

  assign dec_valid_o   = dec_valid_q;
  assign rs_addr_a_o   = rs_addr_a_q;
  assign rs_addr_b_o   = rs_addr_b_q;
  assign rd_addr_o     = rd_addr_q;
  assign imm_o         = imm_q;
  assign pc_o          = pc_q;
  assign alu_src_o     = alu_src_q;
  assign alu_ctrl_o    = alu_ctrl_q;
  assign rd_we_o       = rd_we_q;
  assign mem_re_o      = mem_re_q;
  assign mem_we_o      = mem_we_q;
  assign branch_o      = branch_q;
  assign jump_o        = jump_q;
  assign dec_illegal_o = illegal_q;
  assign ill_cnt_o     = ill_cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb_rv_decode_stage: table-driven, scoreboarded bench for rv_decode_stage.
// The counter is built 2 bits wide so saturation is reached with a handful of illegals.
// Expectations for the M-extension word follow RV_DECODE_MULDIV_EN.

module tb_rv_decode_stage;
  import rv_pkg::*;

  localparam int XLEN = 32;
  localparam int CW   = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              instr_valid_i;
  logic              instr_ready_o;
  logic [31:0]       instr_i;
  logic [XLEN-1:0]   pc_i;
  logic              flush_i;
  logic              dec_valid_o;
  logic              dec_ready_i;
  logic [4:0]        rs_addr_a_o, rs_addr_b_o, rd_addr_o;
  logic [XLEN-1:0]   imm_o, pc_o;
  logic              alu_src_o;
  alu_operations_e   alu_ctrl_o;
  logic              rd_we_o, mem_re_o, mem_we_o, branch_o, jump_o, dec_illegal_o;
  logic [CW-1:0]     ill_cnt_o;

  rv_decode_stage #(.XLEN(XLEN), .ILL_CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i),
    .dec_valid_o(dec_valid_o), .dec_ready_i(dec_ready_i),
    .rs_addr_a_o(rs_addr_a_o), .rs_addr_b_o(rs_addr_b_o), .rd_addr_o(rd_addr_o),
    .imm_o(imm_o), .pc_o(pc_o), .alu_src_o(alu_src_o), .alu_ctrl_o(alu_ctrl_o),
    .rd_we_o(rd_we_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
    .branch_o(branch_o), .jump_o(jump_o), .dec_illegal_o(dec_illegal_o),
    .ill_cnt_o(ill_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]     instr;
    logic [4:0]      rsA, rsB, rd;
    logic [31:0]     imm;
    logic            chkImm;
    logic            aluSrc;
    logic            chkSrc;
    alu_operations_e aluCtrl;
    logic            rdWe, memRe, memWe, branch, jump, illegal;
    logic [31:0]     pc;
    logic [CW-1:0]   cnt;
  } rec_t;

  rec_t vecs[$];
  rec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   expValid = 1'b0;
  logic [CW-1:0] expCnt = '0;

  // Appends one decode vector (inputs plus expected outputs) to the table.
  task automatic addVec(input logic [31:0] instr, input logic [4:0] rsA, input logic [4:0] rsB,
                        input logic [4:0] rd, input logic [31:0] imm, input logic chkImm,
                        input logic aluSrc, input logic chkSrc, input alu_operations_e op,
                        input logic rdWe, input logic memRe, input logic memWe,
                        input logic br, input logic jmp, input logic ill);
    rec_t r;
    r.instr = instr; r.rsA = rsA; r.rsB = rsB; r.rd = rd; r.imm = imm; r.chkImm = chkImm;
    r.aluSrc = aluSrc; r.chkSrc = chkSrc; r.aluCtrl = op; r.rdWe = rdWe; r.memRe = memRe;
    r.memWe = memWe; r.branch = br; r.jump = jmp; r.illegal = ill; r.pc = '0; r.cnt = '0;
    vecs.push_back(r);
  endtask

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compares the presented bundle against a scoreboard record.
  task automatic compareBundle(input rec_t r);
    checkOutput($sformatf("rs_a[%08h]", r.instr), 64'(rs_addr_a_o), 64'(r.rsA));
    checkOutput($sformatf("rs_b[%08h]", r.instr), 64'(rs_addr_b_o), 64'(r.rsB));
    checkOutput($sformatf("rd[%08h]", r.instr), 64'(rd_addr_o), 64'(r.rd));
    checkOutput($sformatf("pc[%08h]", r.instr), 64'(pc_o), 64'(r.pc));
    if (r.chkImm) checkOutput($sformatf("imm[%08h]", r.instr), 64'(imm_o), 64'(r.imm));
    if (r.chkSrc) checkOutput($sformatf("alu_src[%08h]", r.instr), 64'(alu_src_o), 64'(r.aluSrc));
    checkOutput($sformatf("alu_ctrl[%08h]", r.instr), 64'(alu_ctrl_o), 64'(r.aluCtrl));
    checkOutput($sformatf("rd_we[%08h]", r.instr), 64'(rd_we_o), 64'(r.rdWe));
    checkOutput($sformatf("mem_re[%08h]", r.instr), 64'(mem_re_o), 64'(r.memRe));
    checkOutput($sformatf("mem_we[%08h]", r.instr), 64'(mem_we_o), 64'(r.memWe));
    checkOutput($sformatf("branch[%08h]", r.instr), 64'(branch_o), 64'(r.branch));
    checkOutput($sformatf("jump[%08h]", r.instr), 64'(jump_o), 64'(r.jump));
    checkOutput($sformatf("illegal[%08h]", r.instr), 64'(dec_illegal_o), 64'(r.illegal));
    checkOutput($sformatf("ill_cnt[%08h]", r.instr), 64'(ill_cnt_o), 64'(r.cnt));
  endtask

  // Drives one cycle, checks the handshake and any presented bundle, then updates the model.
  task automatic applyStimulus(input bit v, input int idx, input logic [31:0] pc,
                               input bit rdy, input bit fl);
    rec_t r;
    instr_valid_i = v;
    instr_i       = v ? vecs[idx].instr : 32'h0000_0013;
    pc_i          = pc;
    dec_ready_i   = rdy;
    flush_i       = fl;
    #1;
    checkOutput("instr_ready", 64'(instr_ready_o), 64'(!expValid || rdy));
    checkOutput("dec_valid", 64'(dec_valid_o), 64'(expValid));
    if (expValid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard: got empty expected one bundle at %0t", $time);
      end else begin
        compareBundle(sb[0]);
        if (rdy || fl) void'(sb.pop_front());
      end
    end
    if (fl) begin
      expValid = 1'b0;
    end else if (v && (!expValid || rdy)) begin
      r = vecs[idx];
      r.pc = pc;
      if (r.illegal && expCnt != '1) expCnt = expCnt + 1'b1;
      r.cnt = expCnt;
      sb.push_back(r);
      expValid = 1'b1;
    end else if (rdy) begin
      expValid = 1'b0;
    end
    @(posedge clk_i);
    #1;
  endtask

  // Applies reset for one edge and checks the cleared output register.
  task automatic doReset();
    rst_i = 1'b1;
    instr_valid_i = 1'b0;
    flush_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    sb.delete();
    expValid = 1'b0;
    expCnt = '0;
    checkOutput("rst_dec_valid", 64'(dec_valid_o), 64'(0));
    checkOutput("rst_alu_ctrl", 64'(alu_ctrl_o), 64'(OP_NOP));
    checkOutput("rst_ill_cnt", 64'(ill_cnt_o), 64'(0));
    checkOutput("rst_imm", 64'(imm_o), 64'(0));
    checkOutput("rst_pc", 64'(pc_o), 64'(0));
    checkOutput("rst_rd_we", 64'(rd_we_o), 64'(0));
    checkOutput("rst_illegal", 64'(dec_illegal_o), 64'(0));
  endtask

  initial begin
    rst_i = 1'b1; instr_valid_i = 1'b0; instr_i = '0; pc_i = '0; flush_i = 1'b0; dec_ready_i = 1'b1;

    //      instr         rsA rsB rd  imm           cI src cS op       we mr mw br jp ill
    addVec(32'h002081B3, 1,  2,  3,  32'h0,         0, 0, 1, OP_ADD,  1, 0, 0, 0, 0, 0); // 0 add
    addVec(32'h402081B3, 1,  2,  3,  32'h0,         0, 0, 1, OP_SUB,  1, 0, 0, 0, 0, 0); // 1 sub
    addVec(32'hFFF00093, 0,  31, 1,  32'hFFFFFFFF,  1, 1, 1, OP_ADD,  1, 0, 0, 0, 0, 0); // 2 addi -1
    addVec(32'hFE208EE3, 1,  2,  29, 32'hFFFFFFFC,  1, 0, 1, OP_SUB,  0, 0, 0, 1, 0, 0); // 3 beq -4
    addVec(32'h123452B7, 0,  3,  5,  32'h12345000,  1, 1, 1, OP_ADD,  1, 0, 0, 0, 0, 0); // 4 lui
    addVec(32'h0062C233, 5,  6,  4,  32'h0,         0, 0, 1, OP_XOR,  1, 0, 0, 0, 0, 0); // 5 xor
    addVec(32'hFFF4B413, 9,  31, 8,  32'hFFFFFFFF,  1, 1, 1, OP_SLTU, 1, 0, 0, 0, 0, 0); // 6 sltiu
    addVec(32'h00000000, 0,  0,  0,  32'h0,         0, 0, 0, OP_NOP,  0, 0, 0, 0, 0, 1); // 7 zero word
`ifdef RV_DECODE_MULDIV_EN
    addVec(32'h02208133, 1,  2,  2,  32'h0,         0, 0, 1, OP_MUL,  1, 0, 0, 0, 0, 0); // 8 mul
`else
    addVec(32'h02208133, 1,  2,  2,  32'h0,         0, 0, 0, OP_NOP,  0, 0, 0, 0, 0, 1); // 8 mul illegal
`endif
    addVec(32'h008000EF, 0,  8,  1,  32'h00000008,  1, 1, 1, OP_ADD,  1, 0, 0, 0, 1, 0); // 9 jal +8
    addVec(32'h000010E7, 0,  0,  1,  32'h0,         0, 0, 0, OP_NOP,  0, 0, 0, 0, 0, 1); // 10 jalr f3=1
    addVec(32'hFF812303, 2,  24, 6,  32'hFFFFFFF8,  1, 1, 1, OP_ADD,  1, 1, 0, 0, 0, 0); // 11 lw -8
    addVec(32'h00512623, 2,  5,  12, 32'h0000000C,  1, 1, 1, OP_ADD,  0, 0, 1, 0, 0, 0); // 12 sw +12
    addVec(32'h4030D393, 1,  3,  7,  32'h00000403,  1, 1, 1, OP_SRA,  1, 0, 0, 0, 0, 0); // 13 srai
    addVec(32'h02009093, 1,  0,  1,  32'h0,         0, 0, 0, OP_NOP,  0, 0, 0, 0, 0, 1); // 14 slli bit25
    addVec(32'h0020E463, 1,  2,  8,  32'h00000008,  1, 0, 1, OP_SLTU, 0, 0, 0, 1, 0, 0); // 15 bltu +8
    addVec(32'h80000517, 0,  0,  10, 32'h80000000,  1, 1, 1, OP_ADD,  1, 0, 0, 0, 0, 0); // 16 auipc
    addVec(32'h00002063, 0,  0,  0,  32'h0,         0, 0, 0, OP_NOP,  0, 0, 0, 0, 0, 1); // 17 branch f3=2

    $display("[TB] reset");
    doReset();

    $display("[TB] back-to-back stream");
    for (int i = 0; i <= 4; i++) applyStimulus(1'b1, i, 32'h1000 + 32'(4 * i), 1'b1, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 5, 32'h2000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 6, 32'h2004, 1'b0, 1'b0);
    applyStimulus(1'b1, 6, 32'h2004, 1'b1, 1'b0);

    $display("[TB] remaining vectors including illegal and saturation");
    for (int i = 7; i < vecs.size(); i++) applyStimulus(1'b1, i, 32'h3000 + 32'(4 * i), 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 32'h0, 1'b1, 1'b0);
    checkOutput("ill_cnt_saturated", 64'(ill_cnt_o), 64'(expCnt));

    $display("[TB] reset while stalled");
    applyStimulus(1'b1, 11, 32'h4000, 1'b0, 1'b0);
    applyStimulus(1'b1, 12, 32'h4004, 1'b0, 1'b0);
    dec_ready_i = 1'b0;
    doReset();

    $display("[TB] flush while holding, illegal offered");
    applyStimulus(1'b1, 17, 32'h5000, 1'b0, 1'b0);
    applyStimulus(1'b1, 7, 32'h5004, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 32'h0, 1'b1, 1'b0);
    checkOutput("ill_cnt_after_flush", 64'(ill_cnt_o), 64'(1));
    checkOutput("sb_drained", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
